// File: rtl/hour_bcd_loader_if.sv
// Digit-entry bus for hour_bcd_loader: keypad-side strobe/digit/abort in,
// accepted hour, result pulses and entry status out.
interface hour_bcd_loader_if;
  // DIG_VLD is a single-cycle strobe with no backpressure: DIG is sampled on
  // every rising CLK edge where DIG_VLD=1 and is ignored otherwise. CLR is a
  // synchronous abort that overrides a coincident strobe. LOAD and ERR are
  // one-cycle registered result pulses, never high together.
  logic       DIG_VLD;
  logic [3:0] DIG;
  logic       CLR;
  logic [4:0] HOUR;
  logic       LOAD;
  logic       ERR;
  logic       BUSY;
  logic [1:0] PEND_H;
  logic       STATE_DBG;

  modport master (
    output DIG_VLD, DIG, CLR,
    input  HOUR, LOAD, ERR, BUSY, PEND_H, STATE_DBG
  );

  modport slave (
    input  DIG_VLD, DIG, CLR,
    output HOUR, LOAD, ERR, BUSY, PEND_H, STATE_DBG
  );
endinterface

// File: rtl/hour_bcd_loader.sv
// Two-digit BCD hour entry (00..23) producing a registered binary hour and
// LOAD/ERR pulses. Optional inactivity abort: HOUR_BCD_LOADER_TIMEOUT_EN.
module hour_bcd_loader #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic              CLK,
  input logic              RST,
  hour_bcd_loader_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    TENS = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] hour_q, hour_d;
  logic       load_q, load_d;
  logic       err_q, err_d;
  logic [1:0] pend_q, pend_d;
  logic [4:0] value;
  logic       ones_ok;
  logic       timeout;

  // tens*10 + ones as tens*8 + tens*2 + ones; fits 5 bits whenever DIG<=9
  assign value   = {pend_q, 3'b000} + {2'b00, pend_q, 1'b0} + {1'b0, bus.DIG};
  assign ones_ok = (bus.DIG <= 4'd9) && (value <= 5'd23);

`ifdef HOUR_BCD_LOADER_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] idle_cnt_q;

  assign timeout = (state_q == TENS) && !bus.DIG_VLD && !bus.CLR &&
                   (idle_cnt_q == LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idle_cnt_q <= '0;
    end else if (state_q != TENS || bus.DIG_VLD || bus.CLR || timeout) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end
`else
  logic timeout_param_unused;

  assign timeout              = 1'b0;
  assign timeout_param_unused = (TIMEOUT_CYC == 0);
`endif

  // State and result registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      hour_q  <= 5'd0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      load_q  <= load_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.CLR) begin
      state_d = IDLE;
    end else if (bus.DIG_VLD) begin
      case (state_q)
        IDLE:    if (bus.DIG <= 4'd2) state_d = TENS;
        TENS:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
    end
  end

  // Next values of the registered outputs
  always_comb begin
    hour_d = hour_q;
    load_d = 1'b0;
    err_d  = 1'b0;
    pend_d = pend_q;
    if (bus.CLR) begin
      pend_d = 2'd0;
    end else if (bus.DIG_VLD) begin
      case (state_q)
        IDLE: begin
          if (bus.DIG <= 4'd2) pend_d = bus.DIG[1:0];
          else                 err_d  = 1'b1;
        end
        TENS: begin
          pend_d = 2'd0;
          if (ones_ok) begin
            hour_d = value;
            load_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: pend_d = 2'd0;
      endcase
    end else if (timeout) begin
      pend_d = 2'd0;
      err_d  = 1'b1;
    end
  end

  assign bus.HOUR      = hour_q;
  assign bus.LOAD      = load_q;
  assign bus.ERR       = err_q;
  assign bus.BUSY      = (state_q == TENS);
  assign bus.PEND_H    = pend_q;
  assign bus.STATE_DBG = state_q;

endmodule

// File: tb/tb_hour_bcd_loader.sv
// Directed bench for hour_bcd_loader: expected LOAD/ERR events are queued by
// the driver and popped by a monitor whenever the DUT pulses a result.
module tb_hour_bcd_loader;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  logic [6:0] exp_q[$];

  hour_bcd_loader_if bus ();

  hour_bcd_loader #(
    .TIMEOUT_CYC(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=%0d req=%0d", name, act, req);
    end
  endtask

  function automatic void expect_ev(input bit ld, input bit er, input logic [4:0] h);
    exp_q.push_back({ld, er, h});
  endfunction

  // Monitor: every result pulse must match the oldest queued expectation
  always @(negedge CLK) begin
    if (!RST && (bus.LOAD || bus.ERR)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: act={load=%0b err=%0b hour=%0d} req=none",
                 bus.LOAD, bus.ERR, bus.HOUR);
      end else begin
        check("event{load,err,hour}", {25'd0, bus.LOAD, bus.ERR, bus.HOUR}, {25'd0, exp_q.pop_front()});
      end
    end
  end

  // Driver tasks: called at posedge+1, return at the following posedge+1
  task automatic strobe(input logic [3:0] d, input logic clr);
    bus.DIG_VLD = 1'b1;
    bus.DIG     = d;
    bus.CLR     = clr;
    @(posedge CLK);
    #1;
    bus.DIG_VLD = 1'b0;
    bus.CLR     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check_status(input string tag, input logic [4:0] hour,
                              input logic busy, input logic [1:0] pend);
    check({tag, "_hour"}, {27'd0, bus.HOUR}, {27'd0, hour});
    check({tag, "_busy"}, {31'd0, bus.BUSY}, {31'd0, busy});
    check({tag, "_pend"}, {30'd0, bus.PEND_H}, {30'd0, pend});
  endtask

  initial begin
    int n;
    checks      = 0;
    errors      = 0;
    RST         = 1'b1;
    bus.DIG_VLD = 1'b0;
    bus.DIG     = 4'd0;
    bus.CLR     = 1'b0;
    #3;
    check_status("reset", 5'd0, 1'b0, 2'd0);
    check("reset_load", {31'd0, bus.LOAD}, 32'd0);
    check("reset_err", {31'd0, bus.ERR}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // 1 then 7 -> 17
    strobe(4'd1, 1'b0);
    check_status("tens1", 5'd0, 1'b1, 2'd1);
    expect_ev(1'b1, 1'b0, 5'd17);
    strobe(4'd7, 1'b0);
    check_status("h17", 5'd17, 1'b0, 2'd0);
    idle(2);

    // 2 then 4 back-to-back -> rejected, hour keeps 17
    expect_ev(1'b0, 1'b1, 5'd17);
    strobe(4'd2, 1'b0);
    strobe(4'd4, 1'b0);
    check_status("h24_rej", 5'd17, 1'b0, 2'd0);
    idle(1);

    // 5 as tens -> ERR, stays idle; then 0,0 -> 0
    expect_ev(1'b0, 1'b1, 5'd17);
    strobe(4'd5, 1'b0);
    check_status("tens5_rej", 5'd17, 1'b0, 2'd0);
    expect_ev(1'b1, 1'b0, 5'd0);
    strobe(4'd0, 1'b0);
    strobe(4'd0, 1'b0);
    check_status("h00", 5'd0, 1'b0, 2'd0);

    // 2,3 -> 23 (upper boundary)
    expect_ev(1'b1, 1'b0, 5'd23);
    strobe(4'd2, 1'b0);
    strobe(4'd3, 1'b0);
    check_status("h23", 5'd23, 1'b0, 2'd0);
    idle(1);

    // 2, then CLR with a coincident strobe of 3 -> abort, no event
    strobe(4'd2, 1'b0);
    check_status("clr_pre", 5'd23, 1'b1, 2'd2);
    strobe(4'd3, 1'b1);
    check_status("clr_post", 5'd23, 1'b0, 2'd0);
    idle(3);

    // ones digit 10 is not BCD even though 1*10+10 would be <= 23
    expect_ev(1'b0, 1'b1, 5'd23);
    strobe(4'd1, 1'b0);
    strobe(4'd10, 1'b0);
    check_status("ones10_rej", 5'd23, 1'b0, 2'd0);

    // 1,9 -> 19 and 0,5 -> 5
    expect_ev(1'b1, 1'b0, 5'd19);
    strobe(4'd1, 1'b0);
    strobe(4'd9, 1'b0);
    expect_ev(1'b1, 1'b0, 5'd5);
    strobe(4'd0, 1'b0);
    strobe(4'd5, 1'b0);
    check_status("h05", 5'd5, 1'b0, 2'd0);

    // DIG changes without a strobe are ignored
    bus.DIG = 4'd1;
    idle(3);
    check_status("no_strobe", 5'd5, 1'b0, 2'd0);

    // Inactivity in TENS
    strobe(4'd1, 1'b0);
`ifdef HOUR_BCD_LOADER_TIMEOUT_EN
    expect_ev(1'b0, 1'b1, 5'd5);
    n = 0;
    while (bus.BUSY && n < 40) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("timeout_cycles", n, 32'd8);
    check_status("timeout", 5'd5, 1'b0, 2'd0);
    strobe(4'd1, 1'b0);
`else
    n = 0;
    idle(40);
    check_status("no_timeout", 5'd5, 1'b1, 2'd1);
`endif

    // Asynchronous reset mid-entry, checked before the next clock edge
    #2;
    RST = 1'b1;
    #1;
    check_status("async_rst", 5'd0, 1'b0, 2'd0);
    idle(2);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    idle(3);
    check_status("post_rst", 5'd0, 1'b0, 2'd0);

    // Normal entry after reset: 1,2 -> 12
    expect_ev(1'b1, 1'b0, 5'd12);
    strobe(4'd1, 1'b0);
    strobe(4'd2, 1'b0);
    check_status("h12", 5'd12, 1'b0, 2'd0);
    idle(3);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
